// File: rtl/biu.sv
// Bus interface unit: serves eu operand reads / result writes over a shared
// tri-state bus, targeting an internal 8x16 register file or an external port.
module biu #(
  parameter int             DW       = 16,
  parameter int             NREG     = 8,
  parameter int             MEM_TMO  = 15,
  parameter logic [DW-1:0]  ERR_DATA = 16'hDEAD
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs_biu,
  input  logic [1:0]    sel,
  input  logic [1:0]    op_sel,
  input  logic [31:0]   ir,
  inout  wire  [DW-1:0] bus,
  output logic          ready_biu,
  output logic [7:0]    mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          err
);

  localparam int            TW      = $clog2(MEM_TMO + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(MEM_TMO);

  typedef enum logic [2:0] {IDLE, RD_REG, RD_EXT, DRIVE, WR_EXT} state_e;

  state_e          state_q, state_d;
  logic            ready_q, ready_d;
  logic            mem_re_q, mem_re_d;
  logic            mem_we_q, mem_we_d;
  logic            err_q, err_d;
  logic [7:0]      mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic [1:0]      last_op_q, last_op_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [DW-1:0]   rf_q [NREG];
  logic [DW-1:0]   rf_d [NREG];

  logic       cs_act, new_req, hold, is_reg, drive;
  logic [7:0] ext_addr;

  // Only a clean 1 on cs_biu counts; X/Z from an undriven select reads as idle.
  assign cs_act   = (cs_biu === 1'b1);
  assign new_req  = cs_act && (op_sel != 2'b11) && (op_sel != last_op_q);
  assign hold     = cs_act && (op_sel == last_op_q);
  assign is_reg   = sel[1];
  assign ext_addr = {ir[7] | (sel == 2'b01), ir[6:0]};

  // Gated combinationally so the bus is released the same cycle eu moves on.
  assign drive = (state_q == DRIVE) && hold && (op_sel != 2'b10);
  assign bus   = drive ? dout_q : {DW{1'bz}};

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    dout_d      = dout_q;
    last_op_d   = cs_act ? last_op_q : 2'b11;
    tmo_d       = tmo_q;
    rf_d        = rf_q;

    case (state_q)
      IDLE, DRIVE: begin
        if (state_q == DRIVE) begin
          ready_d = 1'b1;
          if (!hold) state_d = IDLE;
        end
        if (new_req) begin
          last_op_d = op_sel;
          state_d   = IDLE;
          if (op_sel == 2'b10) begin
            if (is_reg) begin
              rf_d[ir[29:27]] = bus;
              ready_d         = 1'b1;
            end else begin
              mem_addr_d  = ext_addr;
              mem_wdata_d = bus;
              mem_we_d    = 1'b1;
              ready_d     = 1'b0;
              tmo_d       = '0;
              state_d     = WR_EXT;
            end
          end else if (is_reg) begin
            dout_d  = op_sel[0] ? rf_q[ir[23:21]] : rf_q[ir[26:24]];
            ready_d = 1'b0;
            state_d = RD_REG;
          end else begin
            mem_addr_d = ext_addr;
            mem_re_d   = 1'b1;
            ready_d    = 1'b0;
            tmo_d      = '0;
            state_d    = RD_EXT;
          end
        end
      end
      RD_REG: state_d = DRIVE;
      RD_EXT: begin
        // Ack wins over a coincident timeout. If eu let go meanwhile, drop the data.
        if (mem_ack || tmo_q == TMO_MAX) begin
          dout_d   = mem_ack ? mem_rdata : ERR_DATA;
          err_d    = err_q | ~mem_ack;
          mem_re_d = 1'b0;
          state_d  = hold ? DRIVE : IDLE;
          ready_d  = ~hold;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WR_EXT: begin
        if (mem_ack || tmo_q == TMO_MAX) begin
          err_d    = err_q | ~mem_ack;
          mem_we_d = 1'b0;
          ready_d  = 1'b1;
          state_d  = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dout_q      <= '0;
      last_op_q   <= 2'b11;
      tmo_q       <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      dout_q      <= dout_d;
      last_op_q   <= last_op_d;
      tmo_q       <= tmo_d;
      rf_q        <= rf_d;
    end
  end

  assign ready_biu = ready_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign err       = err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_biu.sv
// Directed bench for biu: reg-file reads/writes, external reads, timeout, reset.
module tb_biu;
  logic        clk = 1'b0;
  logic        rst_n, cs_biu, mem_ack, tb_oe;
  logic [1:0]  sel, op_sel;
  logic [31:0] ir;
  wire  [15:0] bus;
  logic [15:0] tb_bus, mem_rdata, mem_wdata;
  logic [7:0]  mem_addr;
  logic        ready_biu, mem_re, mem_we, err;
  int          n_run = 0, n_fail = 0, n;

  assign bus = tb_oe ? tb_bus : 16'hzzzz;
  always #5 clk = ~clk;

  biu dut (
    .clk(clk), .rst_n(rst_n), .cs_biu(cs_biu), .sel(sel), .op_sel(op_sel), .ir(ir),
    .bus(bus), .ready_biu(ready_biu), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_ir(input int dst, input int sa, input int sb, input int addr);
    return 32'((dst << 27) | (sa << 24) | (sb << 21) | (addr & 8'hff));
  endfunction

  task automatic idle();
    cs_biu = 1'b0; op_sel = 2'b11; tb_oe = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input int dst, input logic [1:0] s, input logic [15:0] d);
    cs_biu = 1'b1; op_sel = 2'b10; sel = s; ir = mk_ir(dst, 0, 0, 0);
    tb_oe = 1'b1; tb_bus = d;
    @(negedge clk);
    idle();
  endtask

  // Issue a read; count negedges with ready low. dly>0 acks on the dly-th low cycle.
  task automatic acc(input logic [1:0] op, input logic [1:0] s, input logic [31:0] irv,
                     input int dly, input logic [15:0] d, output int cnt);
    cs_biu = 1'b1; op_sel = op; sel = s; ir = irv; cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (ready_biu) break;
      cnt++;
      if (dly > 0 && cnt == dly) begin
        mem_ack = 1'b1; mem_rdata = d;
      end
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cs_biu = 1'b0; op_sel = 2'b11; sel = 2'b00; ir = '0;
    mem_ack = 1'b0; mem_rdata = '0; tb_oe = 1'b0; tb_bus = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready_biu), 1);
    chk("rst_re",    32'(mem_re), 0);
    chk("rst_we",    32'(mem_we), 0);
    chk("rst_addr",  32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_err",   32'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    wr(2, 2'b10, 16'h1234);
    wr(1, 2'b10, 16'h0005);
    wr(3, 2'b10, 16'h0007);

    acc(2'b00, 2'b10, mk_ir(0, 2, 0, 0), 0, 16'h0, n);
    chk("rd_lat", 32'(n), 2);
    chk("rd_bus", 32'(bus), 32'h1234);
    idle();

    acc(2'b00, 2'b10, mk_ir(0, 1, 3, 0), 0, 16'h0, n);
    chk("b2b_a", 32'(bus), 32'h0005);
    @(negedge clk);
    chk("b2b_hold", 32'(bus), 32'h0005);
    acc(2'b01, 2'b10, mk_ir(0, 1, 3, 0), 0, 16'h0, n);
    chk("b2b_lat", 32'(n), 2);
    chk("b2b_b", 32'(bus), 32'h0007);

    // Write straight out of DRIVE: biu must release the bus at once.
    op_sel = 2'b10; sel = 2'b10; ir = mk_ir(4, 0, 0, 0); tb_oe = 1'b1; tb_bus = 16'hBEEF;
    #1;
    chk("wr_nodrv", 32'(bus), 32'hBEEF);
    chk("wr_rdy", 32'(ready_biu), 1);
    @(negedge clk);
    chk("wr_nodrv2", 32'(bus), 32'hBEEF);
    chk("wr_rdy2", 32'(ready_biu), 1);
    idle();
    acc(2'b00, 2'b10, mk_ir(0, 4, 0, 0), 0, 16'h0, n);
    chk("wr_rf4", 32'(bus), 32'hBEEF);
    idle();

    acc(2'b00, 2'b01, mk_ir(0, 0, 0, 8'h05), 3, 16'h00A5, n);
    chk("per_addr", 32'(mem_addr), 32'h85);
    chk("per_lat", 32'(n), 4);
    chk("per_bus", 32'(bus), 32'h00A5);
    chk("per_re", 32'(mem_re), 0);
    chk("per_err", 32'(err), 0);
    idle();

    acc(2'b00, 2'b00, mk_ir(0, 0, 0, 8'h10), 0, 16'h0, n);
    chk("tmo_lat", 32'(n), 17);
    chk("tmo_bus", 32'(bus), 32'hDEAD);
    chk("tmo_err", 32'(err), 1);
    chk("tmo_addr", 32'(mem_addr), 32'h10);
    idle();

    cs_biu = 1'b1; op_sel = 2'b10; sel = 2'b00; ir = mk_ir(0, 0, 0, 8'h22);
    tb_oe = 1'b1; tb_bus = 16'h1111;
    @(negedge clk);
    tb_oe = 1'b0;
    chk("wx_we", 32'(mem_we), 1);
    chk("wx_wdata", 32'(mem_wdata), 32'h1111);
    chk("wx_addr", 32'(mem_addr), 32'h22);
    chk("wx_rdy", 32'(ready_biu), 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ar_rdy", 32'(ready_biu), 1);
    chk("ar_we", 32'(mem_we), 0);
    chk("ar_re", 32'(mem_re), 0);
    chk("ar_err", 32'(err), 0);
    chk("ar_addr", 32'(mem_addr), 0);
    chk("ar_wdata", 32'(mem_wdata), 0);
    cs_biu = 1'b0; op_sel = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    acc(2'b00, 2'b10, mk_ir(0, 2, 0, 0), 0, 16'h0, n);
    chk("ar_rf2", 32'(bus), 0);
    idle();

    wr(0, 2'b11, 16'h00C3);
    acc(2'b00, 2'b10, mk_ir(0, 0, 0, 0), 0, 16'h0, n);
    chk("rf0_sel11", 32'(bus), 32'h00C3);
    idle();

    acc(2'b01, 2'b00, mk_ir(0, 0, 0, 8'h40), 16, 16'h0BAD, n);
    chk("ackw_lat", 32'(n), 17);
    chk("ackw_bus", 32'(bus), 32'h0BAD);
    chk("ackw_err", 32'(err), 0);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
